// File: rtl/bus_pkg.sv
// Shared encodings for the split-transaction bus arbiter: FSM states, slave ids, sizes.
// Pure definitions; no timing or flow control of its own.
package bus_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES  = 3;

  localparam logic [1:0] SLV_S1   = 2'd0;
  localparam logic [1:0] SLV_S2   = 2'd1;
  localparam logic [1:0] SLV_S3   = 2'd2;
  localparam logic [1:0] SLV_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_M1 = 2'd1,
    ST_GRANT_M2 = 2'd2
  } arb_state_t;

  // An invalid id reads as permanently busy so it can never be granted.
  function automatic logic slave_splitting(input logic [NUM_SLAVES-1:0] split_en,
                                           input logic [1:0] id);
    case (id)
      SLV_S1:  return split_en[0];
      SLV_S2:  return split_en[1];
      SLV_S3:  return split_en[2];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/grant_watchdog.sv
// Grant watchdog: counts grant cycles and fires when the owner overstays LIMIT cycles (0 = off).
// expire is combinational in the limit cycle; timeout is its registered one-cycle pulse.
module grant_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic done,
  output logic expire,
  output logic timeout
);

  logic [15:0] cnt;

  // Held at zero outside a grant, so every new grant starts counting from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (!enable) cnt <= '0;
    else             cnt <= cnt + 16'd1;
  end

  generate
    if (LIMIT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = enable & ~done & (cnt == 16'(LIMIT - 1));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout <= 1'b0;
    else       timeout <= expire;
  end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master/three-slave bus arbiter with split parking and grant watchdog; grant 1 cycle after request.
// Tie policy: fixed M1 priority, or least-recently-granted when ARB_ROUND_ROBIN_EN is defined.
module split_bus_arbiter
  import bus_pkg::*;
#(
  parameter int          SLAVE_LEN      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m1_request,
  input  logic                 m2_request,
  input  logic [SLAVE_LEN-1:0] m1_slave_sel,
  input  logic [SLAVE_LEN-1:0] m2_slave_sel,
  input  logic                 trans_done,
  input  logic [2:0]           slave_split_en,
  output logic                 m1_grant,
  output logic                 m2_grant,
  output logic                 arbiter_busy,
  output logic                 bus_busy,
  output logic [SLAVE_LEN-1:0] bus_slave_sel,
  output logic [1:0]           split_parked,
  output logic                 sel_error,
  output logic                 timeout
);

  arb_state_t state, state_nxt;
  logic [NUM_MASTERS-1:0]                park, park_nxt;
  logic [NUM_MASTERS-1:0][SLAVE_LEN-1:0] park_slv, park_slv_nxt;
  logic [SLAVE_LEN-1:0]                  sel_nxt;
  logic [NUM_MASTERS-1:0]                req_q, rel, elig;
  logic tie_m1, owner, wd_expire, sel_err_nxt;

  // rel: parked master whose slave finished splitting; elig: fresh request to a free slave.
  assign rel[0]  = park[0] & m1_request & ~slave_splitting(slave_split_en, park_slv[0]);
  assign rel[1]  = park[1] & m2_request & ~slave_splitting(slave_split_en, park_slv[1]);
  assign elig[0] = m1_request & (m1_slave_sel != SLV_NONE) & ~park[0]
                 & ~slave_splitting(slave_split_en, m1_slave_sel)
                 & ~(park[1] & (park_slv[1] == m1_slave_sel));
  assign elig[1] = m2_request & (m2_slave_sel != SLV_NONE) & ~park[1]
                 & ~slave_splitting(slave_split_en, m2_slave_sel)
                 & ~(park[0] & (park_slv[0] == m2_slave_sel));

  assign owner       = (state == ST_GRANT_M2);
  assign sel_err_nxt = (m1_request & ~req_q[0] & (m1_slave_sel == SLV_NONE))
                     | (m2_request & ~req_q[1] & (m2_slave_sel == SLV_NONE));

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         last_m1 <= 1'b0;
    else if (state == ST_IDLE && state_nxt != ST_IDLE) last_m1 <= (state_nxt == ST_GRANT_M1);
  end
  assign tie_m1 = ~last_m1;
`else
  assign tie_m1 = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    park_nxt     = park;
    park_slv_nxt = park_slv;
    sel_nxt      = bus_slave_sel;
    if (park[0] && !m1_request) park_nxt[0] = 1'b0;
    if (park[1] && !m2_request) park_nxt[1] = 1'b0;
    case (state)
      ST_IDLE: begin
        sel_nxt = SLV_S1;
        if (rel[0]) begin
          state_nxt   = ST_GRANT_M1;
          sel_nxt     = park_slv[0];
          park_nxt[0] = 1'b0;
        end else if (rel[1]) begin
          state_nxt   = ST_GRANT_M2;
          sel_nxt     = park_slv[1];
          park_nxt[1] = 1'b0;
        end else if (elig[0] && (!elig[1] || tie_m1)) begin
          state_nxt = ST_GRANT_M1;
          sel_nxt   = m1_slave_sel;
        end else if (elig[1]) begin
          state_nxt = ST_GRANT_M2;
          sel_nxt   = m2_slave_sel;
        end
      end
      ST_GRANT_M1, ST_GRANT_M2: begin
        // Completion and watchdog both beat a simultaneous split: nothing is parked.
        if (trans_done || wd_expire) begin
          state_nxt = ST_IDLE;
          sel_nxt   = SLV_S1;
        end else if (slave_splitting(slave_split_en, bus_slave_sel)) begin
          state_nxt           = ST_IDLE;
          sel_nxt             = SLV_S1;
          park_nxt[owner]     = 1'b1;
          park_slv_nxt[owner] = bus_slave_sel;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      park          <= '0;
      park_slv      <= '0;
      bus_slave_sel <= '0;
      req_q         <= '0;
      sel_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      park          <= park_nxt;
      park_slv      <= park_slv_nxt;
      bus_slave_sel <= sel_nxt;
      req_q         <= {m2_request, m1_request};
      sel_error     <= sel_err_nxt;
    end
  end

  grant_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (state != ST_IDLE),
    .done    (trans_done),
    .expire  (wd_expire),
    .timeout (timeout)
  );

  assign m1_grant     = (state == ST_GRANT_M1);
  assign m2_grant     = (state == ST_GRANT_M2);
  assign arbiter_busy = (state != ST_IDLE);
  assign bus_busy     = m1_grant | m2_grant;
  assign split_parked = park;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Vector-table bench for split_bus_arbiter with a watchdog limit of 8 cycles.
module tb_split_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic       m1r, m2r;
    logic [1:0] s1, s2;
    logic       done;
    logic [2:0] split;
  } in_t;

  typedef struct packed {
    logic [1:0] g;      // {m2_grant, m1_grant}
    logic [1:0] sel;
    logic [1:0] park;
    logic       err, to;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic       m1_request = 0, m2_request = 0, trans_done = 0;
  logic [1:0] m1_slave_sel = 0, m2_slave_sel = 0;
  logic [2:0] slave_split_en = 0;
  logic       m1_grant, m2_grant, arbiter_busy, bus_busy, sel_error, timeout;
  logic [1:0] bus_slave_sel, split_parked;

  int   n_vec = 0, n_bad = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  split_bus_arbiter #(.SLAVE_LEN(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel), .trans_done(trans_done),
    .slave_split_en(slave_split_en), .m1_grant(m1_grant), .m2_grant(m2_grant),
    .arbiter_busy(arbiter_busy), .bus_busy(bus_busy), .bus_slave_sel(bus_slave_sel),
    .split_parked(split_parked), .sel_error(sel_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic m1r, m2r, input logic [1:0] s1, s2,
                              input logic done, input logic [2:0] sp,
                              input logic [1:0] g, sel, pk, input logic err, to);
    vec_t v;
    v.i = '{m1r: m1r, m2r: m2r, s1: s1, s2: s2, done: done, split: sp};
    v.o = '{g: g, sel: sel, park: pk, err: err, to: to};
    return v;
  endfunction

  task automatic drive(input in_t i);
    m1_request     = i.m1r;
    m2_request     = i.m2r;
    m1_slave_sel   = i.s1;
    m2_slave_sel   = i.s2;
    trans_done     = i.done;
    slave_split_en = i.split;
  endtask

  task automatic check(input out_t e, input string nm);
    out_t a;
    logic busy;
    busy  = |e.g;
    a.g   = {m2_grant, m1_grant};
    a.sel = busy ? bus_slave_sel : e.sel;   // slave id only meaningful while the bus is owned
    a.park = split_parked;
    a.err = sel_error;
    a.to  = timeout;
    n_vec++;
    if (a !== e || arbiter_busy !== busy || bus_busy !== busy) begin
      n_bad++;
      $display("FAIL %s: got g=%b sel=%0d park=%b err=%b to=%b abusy=%b bbusy=%b, want g=%b sel=%0d park=%b err=%b to=%b busy=%b",
               nm, a.g, a.sel, a.park, a.err, a.to, arbiter_busy, bus_busy,
               e.g, e.sel, e.park, e.err, e.to, busy);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    drive(v.i);
    exp_q.push_back(v.o);
    @(posedge clk);
    #1;
    check(exp_q.pop_front(), nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check(exp_q.pop_front(), "reset_state");
    @(negedge clk) reset = 1'b0;

    //           m1r m2r s1 s2 done split   g      sel    park err to
    tbl.push_back(mk(1, 1, 0, 2, 0, 3'b000, 2'b01, 2'd0, 2'b00, 0, 0)); // tie -> M1
    tbl.push_back(mk(1, 1, 0, 2, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0)); // mandatory idle
    tbl.push_back(mk(1, 1, 0, 2, 0, 3'b000, RR ? 2'b10 : 2'b01, RR ? 2'd2 : 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(RR, !RR, 0, 2, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(RR, !RR, 0, 2, 0, 3'b000, RR ? 2'b01 : 2'b10, RR ? 2'd0 : 2'd2, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3'b000, 2'b01, 2'd1, 2'b00, 0, 0)); // simple grant to S2
    tbl.push_back(mk(0, 0, 1, 0, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 2'b01, 2'd0, 2'b00, 0, 0)); // M1 on S1
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0)); // split -> park
    tbl.push_back(mk(1, 1, 0, 1, 0, 3'b001, 2'b10, 2'd1, 2'b01, 0, 0)); // M2 to other slave
    tbl.push_back(mk(1, 0, 0, 1, 1, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0)); // M2 to parked slave refused
    tbl.push_back(mk(1, 1, 0, 0, 0, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3'b000, 2'b01, 2'd0, 2'b00, 0, 0)); // split clears -> M1 first
    tbl.push_back(mk(0, 1, 0, 0, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3'b000, 2'b10, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 3'b000, 2'b01, 2'd2, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 3'b100, 2'b00, 2'd0, 2'b01, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 3'b100, 2'b00, 2'd0, 2'b00, 0, 0)); // parked master gives up
    tbl.push_back(mk(0, 0, 2, 0, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 2'b10, 2'd1, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'b010, 2'b00, 2'd0, 2'b00, 0, 0)); // done beats split
    tbl.push_back(mk(0, 1, 0, 3, 0, 3'b000, 2'b00, 2'd0, 2'b00, 1, 0)); // invalid id
    tbl.push_back(mk(0, 1, 0, 3, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 3'b000, 2'b00, 2'd0, 2'b00, 1, 0));
    tbl.push_back(mk(0, 1, 3, 2, 0, 3'b100, 2'b00, 2'd0, 2'b00, 0, 0)); // target busy splitting
    tbl.push_back(mk(0, 1, 3, 2, 0, 3'b000, 2'b10, 2'd2, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 3, 2, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 2'b01, 2'd0, 2'b00, 0, 0)); // both masters parked
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 3'b001, 2'b10, 2'd1, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 3'b011, 2'b00, 2'd0, 2'b11, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 3'b010, 2'b01, 2'd0, 2'b10, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 3'b010, 2'b00, 2'd0, 2'b10, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 2'b10, 2'd1, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Watchdog: grant held for exactly 8 cycles, then a single timeout pulse.
    for (int k = 0; k < 8; k++)
      apply(mk(1, 0, 2, 0, 0, 3'b000, 2'b01, 2'd2, 2'b00, 0, 0), $sformatf("wd_hold%0d", k));
    apply(mk(0, 0, 2, 0, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 1), "wd_fire");
    apply(mk(0, 0, 2, 0, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0), "wd_after");

    // Asynchronous reset while M2 owns the bus and M1 is parked.
    apply(mk(1, 0, 0, 0, 0, 3'b000, 2'b01, 2'd0, 2'b00, 0, 0), "rst_g1");
    apply(mk(1, 0, 0, 0, 0, 3'b001, 2'b00, 2'd0, 2'b01, 0, 0), "rst_park");
    apply(mk(1, 1, 0, 1, 0, 3'b001, 2'b10, 2'd1, 2'b01, 0, 0), "rst_g2");
    #2 reset = 1'b1;
    #1;
    exp_q.push_back('0);
    check(exp_q.pop_front(), "rst_async");
    @(negedge clk);
    reset = 1'b0;
    drive('0);
    apply(mk(0, 0, 0, 0, 0, 3'b000, 2'b00, 2'd0, 2'b00, 0, 0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
